// File: rtl/regfile_proc_sequencer_pkg.sv
// Shared types and constants for the register-file procedure sequencer.
package regfile_proc_sequencer_pkg;
  localparam int DW    = 24;
  localparam int AW    = 4;
  localparam int CW    = 3;
  localparam int NSTEP = 8;

  localparam logic [AW-1:0] PROC0_REG = 4'd6;
  localparam logic [AW-1:0] PROC1_REG = 4'd7;
  localparam logic [AW-1:0] ADD_REG   = 4'd9;

  localparam logic [CW-1:0] OP_END  = 3'd0;
  localparam logic [CW-1:0] OP_ADD  = 3'd1;
  localparam logic [CW-1:0] OP_ROT  = 3'd4;
  localparam logic [CW-1:0] OP_SWAP = 3'd7;

  localparam logic [2:0] LAST_STEP = 3'(NSTEP - 1);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, SWAP2, DONE} state_t;
endpackage

// File: rtl/regfile_step_alu.sv
// Decodes one step code into register-file addresses, write enable and write data.
// Addresses depend only on the code so the read-data path never feeds back into them.
module regfile_step_alu
  import regfile_proc_sequencer_pkg::*;
(
  input  logic [CW-1:0] code,
  input  logic [DW-1:0] outa,
  input  logic [DW-1:0] outb,
  output logic          we,
  output logic [DW-1:0] data,
  output logic [AW-1:0] dst,
  output logic [AW-1:0] src0,
  output logic [AW-1:0] src1
);
  logic          is_add;
  logic          is_rot;
  logic [CW-1:0] rel;

  assign is_add = (code >= OP_ADD) && (code < OP_ROT);
  assign is_rot = (code >= OP_ROT) && (code < OP_SWAP);
  assign rel    = is_add ? (code - OP_ADD) : (is_rot ? (code - OP_ROT) : '0);

  // Swap's first cycle also targets reg0, which rel==0 already gives.
  assign we   = (code != OP_END);
  assign dst  = {{(AW-CW){1'b0}}, rel};
  assign src0 = dst;
  assign src1 = (code == OP_SWAP) ? {{(AW-1){1'b0}}, 1'b1} : ADD_REG;

  always_comb begin
    data = '0;
    if (is_add)
      data = outa + outb;
    else if (is_rot)
      data = {outa[DW-5:0], outa[DW-1:DW-4]};
    else if (code == OP_SWAP)
      data = outb;
  end
endmodule

// File: rtl/regfile_proc_sequencer.sv
// Runs a stored procedure word as read-modify-write steps on colour registers 0..2;
// passes host accesses straight through to the register file while idle.
module regfile_proc_sequencer
  import regfile_proc_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          proc_sel,
  output logic          busy,
  output logic          done,
  output logic [2:0]    step_idx,
  output logic          host_gnt,
  input  logic          host_we,
  input  logic [AW-1:0] host_dst,
  input  logic [AW-1:0] host_src0,
  input  logic [AW-1:0] host_src1,
  input  logic [DW-1:0] host_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_dst,
  output logic [AW-1:0] rf_src0,
  output logic [AW-1:0] rf_src1,
  output logic [DW-1:0] rf_data,
  input  logic [DW-1:0] rf_outa,
  input  logic [DW-1:0] rf_outb
);
  state_t        state, state_nxt;
  logic [DW-1:0] word;
  logic [DW-1:0] tmp;
  logic [2:0]    step;
  logic          sel;
  logic [CW-1:0] code;
  logic          last;

  logic          alu_we;
  logic [DW-1:0] alu_data;
  logic [AW-1:0] alu_dst, alu_src0, alu_src1;

  assign code     = word[step*CW +: CW];
  assign last     = (step == LAST_STEP);
  assign step_idx = step;
  assign host_gnt = !busy;

  regfile_step_alu u_alu (
    .code (code),
    .outa (rf_outa),
    .outb (rf_outb),
    .we   (alu_we),
    .data (alu_data),
    .dst  (alu_dst),
    .src0 (alu_src0),
    .src1 (alu_src1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= '0;
      tmp   <= '0;
      step  <= '0;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:  if (start) begin
                 sel  <= proc_sel;
                 step <= '0;
               end
        FETCH: word <= rf_outa;
        EXEC:  if (code == OP_SWAP)
                 tmp <= rf_outa;
               else if (code != OP_END && !last)
                 step <= step + 3'd1;
        SWAP2: if (!last) step <= step + 3'd1;
        default: ;
      endcase
    end
  end

  // Control and addresses are kept apart from the data mux so read data never loops back.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rf_we     = 1'b0;
    rf_dst    = '0;
    rf_src0   = '0;
    rf_src1   = '0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        rf_we   = host_we;
        rf_dst  = host_dst;
        rf_src0 = host_src0;
        rf_src1 = host_src1;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        rf_src0   = sel ? PROC1_REG : PROC0_REG;
        state_nxt = EXEC;
      end
      EXEC: begin
        rf_we   = alu_we;
        rf_dst  = alu_dst;
        rf_src0 = alu_src0;
        rf_src1 = alu_src1;
        if (code == OP_END)       state_nxt = DONE;
        else if (code == OP_SWAP) state_nxt = SWAP2;
        else if (last)            state_nxt = DONE;
      end
      SWAP2: begin
        rf_we     = 1'b1;
        rf_dst    = {{(AW-1){1'b0}}, 1'b1};
        state_nxt = last ? DONE : EXEC;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) rf_we = 1'b0;
  end

  always_comb begin
    rf_data = alu_data;
    case (state)
      IDLE:    rf_data = host_data;
      SWAP2:   rf_data = tmp;
      default: ;
    endcase
  end
endmodule

// File: doc/regfile_proc_sequencer.md
Name: regfile_proc_sequencer

Overview:
Sequences the 16x24-bit register file through a stored procedure: a 24-bit procedure word (8 packed 3-bit step codes) is fetched from a register and each step is executed as a read-modify-write on the colour registers 0..2. When idle, the block passes host register-file accesses straight through. When busy, it owns the single write port. It sits between the CPU datapath (host) and the register file.

Parameters:
DW, 24, register data width
AW, 4, register address width
CW, 3, step code width
NSTEP, 8, steps per procedure word (NSTEP*CW == DW)
PROC0_REG, 6, register holding procedure 0
PROC1_REG, 7, register holding procedure 1
ADD_REG, 9, register supplying the addend for add steps

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin procedure (sampled only in IDLE)
proc_sel  in  1  0: PROC0_REG, 1: PROC1_REG (sampled with start)
busy  out  1  high from FETCH through DONE
done  out  1  one-cycle pulse in DONE
step_idx  out  3  index of step being executed
host_gnt  out  1  equals !busy
host_we  in  1  host write enable
host_dst  in  AW  host write address
host_src0  in  AW  host read address a
host_src1  in  AW  host read address b
host_data  in  DW  host write data
rf_we  out  1  to regfile we
rf_dst  out  AW  to regfile dst
rf_src0  out  AW  to regfile src0
rf_src1  out  AW  to regfile src1
rf_data  out  DW  to regfile data
rf_outa  in  DW  regfile read data a (combinational)
rf_outb  in  DW  regfile read data b (combinational)

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, busy=0, done=0, step_idx=0, proc word and tmp = 0. While rst_n=0, rf_we is forced to 0 combinationally.
- IDLE: rf_* = host_* passthrough (combinational). start=1 latches proc_sel; next state FETCH. The host access in the start cycle still completes.
- FETCH (1 cycle): rf_src0 = selected proc reg, rf_we=0; latch rf_outa into the proc word; step_idx=0; go to EXEC.
- EXEC: code = word[3*step_idx +: 3].
  - code 0: no write; go to DONE.
  - codes 1..3: src0 = code-1, src1 = ADD_REG, dst = code-1, data = (outa + outb) mod 2^24, carry dropped.
  - codes 4..6: src0 = dst = code-4, data = {outa[19:0], outa[23:20]} (rotate left by 4).
  - code 7: swap reg0/reg1. Cycle A: src0=0, src1=1, dst=0, data=outb, tmp<=outa; go to SWAP2. SWAP2: dst=1, data=tmp; then continue as a normal step end.
  - Step end: if step_idx==NSTEP-1, go to DONE; else step_idx+1 and stay in EXEC.
- DONE: done=1, busy=1, rf_we=0; next state IDLE.
- Host accesses while busy are ignored (host_gnt=0). No queuing.
- start while busy is ignored.
- Reset mid-procedure aborts immediately to IDLE. No partial-step write occurs in the reset cycle.
- Latency: cycles from start to done = 2 + (number of executed steps) + (number of code-7 steps) + (1 if terminated by code 0).

Decomposition:
- Shared package: state enum (IDLE, FETCH, EXEC, SWAP2, DONE), step code constants (OP_END=0, OP_ADD base 1, OP_ROT base 4, OP_SWAP=7), and the register index constants PROC0_REG, PROC1_REG, ADD_REG.
- Sub-module: regfile_step_alu. Combinational; takes code, outa, outb; returns data, dst, src0 and src1. The FSM and the port mux stay in the top module.

Test Plan:
- Reset defaults, start, proc_sel=1 (reg7 = codes 1,2,3,4,5,6,7,0) -> reg0=0x0C0206, reg1=0x01100B, reg2=0x808804; done pulses exactly 11 cycles after the start cycle.
- proc_sel=0 (reg6=0) -> no rf_we during busy; done pulses 3 cycles after start.
- Host writes reg0=0xF00000 and reg6=0x000001, then start with proc_sel=0 -> reg0=0x100000 (carry dropped).
- host_we=1 to reg5 during busy -> reg5 unchanged, host_gnt=0; the same write once idle -> reg5 updated.
- rst_n=0 asserted in the SWAP2 cycle -> busy=0 next cycle, reg1 not written; start after reset behaves normally.
- reg7=0x249249 (all code 1) -> reg0 = 0x901100 + 8*0x200000 mod 2^24 = 0x901100; done at start+10.
